// File: rtl/clock_div_multi.sv
// clock_div_multi: NCH-channel programmable clock divider.
//
// Each channel has its own counter and runs from clk_in. The period (div) and the
// high time (high) can be changed while running. A new pair is held in shadow
// registers and only becomes active at the end of a period, so clk_out never
// produces a short pulse. A load with div < 2 is rejected and sets a sticky error
// flag for that channel.
//
// Parameters:
//   NCH          number of independent channels
//   WIDTH        counter / divisor width in bits
//   DEFAULT_DIV  divisor active after reset (>= 2, < 2**WIDTH)
//   DEFAULT_HIGH high time active after reset, in clk_in cycles
//
// Ports:
//   clk_in    in   1          sole clock, posedge
//   reset     in   1          synchronous, active-high
//   en        in   NCH        per-channel run enable
//   load      in   NCH        per-channel strobe, captures that channel's div_in/high_in slice
//   div_in    in   NCH*WIDTH  period in cycles, channel k at [k*WIDTH +: WIDTH]
//   high_in   in   NCH*WIDTH  high cycles per period, same slicing
//   clk_out   out  NCH        divided output, registered, high phase first
//   pend      out  NCH        a loaded value is waiting for the period boundary
//   err       out  NCH        sticky illegal-divisor flag, cleared by reset or a valid load
//   tick_out  out  NCH        (only with CLKDIV_TICK_EN) one-cycle pulse that coincides with
//                             the first high cycle of every period
//
// Configuration macro: CLKDIV_TICK_EN adds the tick_out port and its logic.
module clock_div_multi #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned WIDTH        = 25,
  parameter int unsigned DEFAULT_DIV  = 32000000,
  parameter int unsigned DEFAULT_HIGH = 16000000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic [NCH*WIDTH-1:0] high_in,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       pend,
`ifdef CLKDIV_TICK_EN
  output logic [NCH-1:0]       tick_out,
`endif
  output logic [NCH-1:0]       err
);

  localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_HIGH);

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    logic [WIDTH-1:0] div_sl, high_sl;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
    logic [WIDTH-1:0] pnd_div_q, pnd_div_d, pnd_high_q, pnd_high_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             load_ok, load_bad, wrap;

    assign div_sl   = div_in[g*WIDTH +: WIDTH];
    assign high_sl  = high_in[g*WIDTH +: WIDTH];
    assign load_ok  = load[g] && (div_sl >= WIDTH'(2));
    assign load_bad = load[g] && (div_sl < WIDTH'(2));
    // Last cycle of the current period.
    assign wrap     = (cnt_q == act_div_q - WIDTH'(1));

    always_comb begin
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
      pnd_div_d  = pnd_div_q;
      pnd_high_d = pnd_high_q;
      pend_d     = pend_q;
      err_d      = err_q;

      clk_d = en[g] && (cnt_q < act_high_q);

      if (load_bad) begin
        err_d = 1'b1;
      end else if (load_ok) begin
        err_d = 1'b0;
      end

      if (!en[g] || wrap) begin
        // Period boundary, or idle: a fresh load bypasses the shadow registers,
        // otherwise any pending value is committed now.
        cnt_d = '0;
        if (load_ok) begin
          act_div_d  = div_sl;
          act_high_d = high_sl;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          act_div_d  = pnd_div_q;
          act_high_d = pnd_high_q;
          pend_d     = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (load_ok) begin
          pnd_div_d  = div_sl;
          pnd_high_d = high_sl;
          pend_d     = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt_q      <= '0;
        act_div_q  <= DefDiv;
        act_high_q <= DefHigh;
        pnd_div_q  <= DefDiv;
        pnd_high_q <= DefHigh;
        pend_q     <= 1'b0;
        err_q      <= 1'b0;
        clk_q      <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_div_q  <= act_div_d;
        act_high_q <= act_high_d;
        pnd_div_q  <= pnd_div_d;
        pnd_high_q <= pnd_high_d;
        pend_q     <= pend_d;
        err_q      <= err_d;
        clk_q      <= clk_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign pend[g]    = pend_q;
    assign err[g]     = err_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q, tick_d;

    // Registered from the first cycle of a period, so it lines up with clk_out rising.
    always_comb begin
      tick_d = en[g] && (cnt_q == '0);
    end

    always_ff @(posedge clk_in) begin
      if (reset) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= tick_d;
      end
    end

    assign tick_out[g] = tick_q;
`endif
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed bench for clock_div_multi with NCH=2, WIDTH=8,
// DEFAULT_DIV=10, DEFAULT_HIGH=5. Each step drives inputs just after a rising edge
// and checks {clk_out, pend, err} just after the following edge.
module tb_clock_div_multi;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  en, load;
  logic [15:0] div_in, high_in;
  logic [1:0]  clk_out, pend, err;
`ifdef CLKDIV_TICK_EN
  logic [1:0]  tick_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  clock_div_multi #(
    .NCH          (2),
    .WIDTH        (8),
    .DEFAULT_DIV  (10),
    .DEFAULT_HIGH (5)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .div_in   (div_in),
    .high_in  (high_in),
    .clk_out  (clk_out),
    .pend     (pend),
`ifdef CLKDIV_TICK_EN
    .tick_out (tick_out),
`endif
    .err      (err)
  );

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One edge, then compare {clk_out, pend, err}.
  task automatic cyc(input string tag, input logic [1:0] c, input logic [1:0] p,
                     input logic [1:0] e);
    @(posedge clk_in);
    #1;
    chk(tag, {clk_out, pend, err}, {c, p, e});
  endtask

  // Whole periods starting at cnt=0, no pending value.
  task automatic wave(input string tag, input int div, input int high, input int reps,
                      input logic [1:0] mask, input logic [1:0] e);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < div; i++) begin
        @(posedge clk_in);
        #1;
        chk(tag, {clk_out, pend, err}, {((i < high) ? mask : 2'b00), 2'b00, e});
`ifdef CLKDIV_TICK_EN
        chk({tag, "_tick"}, {4'b0000, tick_out}, {4'b0000, ((i == 0) ? mask : 2'b00)});
`endif
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    en      = 2'b00;
    load    = 2'b00;
    div_in  = '0;
    high_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset", {clk_out, pend, err}, 6'b000000);

    // 1: default 5 high / 5 low on ch0, ch1 idle
    reset = 1'b0;
    en    = 2'b01;
    wave("s1_default", 10, 5, 2, 2'b01, 2'b00);

    // 2: load 4/1 at cnt=3, applied at the wrap (cnt=9)
    for (int i = 0; i < 3; i++) cyc("s2_pre", 2'b01, 2'b00, 2'b00);
    load = 2'b01; div_in = {8'd0, 8'd4}; high_in = {8'd0, 8'd1};
    cyc("s2_load", 2'b01, 2'b01, 2'b00);
    load = 2'b00;
    cyc("s2_cnt4", 2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) cyc("s2_low", 2'b00, 2'b01, 2'b00);
    cyc("s2_wrap", 2'b00, 2'b00, 2'b00);
    wave("s2_new", 4, 1, 2, 2'b01, 2'b00);

    // 3: illegal div=1 rejected, then a valid 6/3 clears err
    load = 2'b01; div_in = {8'd0, 8'd1}; high_in = {8'd0, 8'd3};
    cyc("s3_bad", 2'b01, 2'b00, 2'b01);
    load = 2'b00;
    for (int i = 0; i < 3; i++) cyc("s3_keep", 2'b00, 2'b00, 2'b01);
    wave("s3_still", 4, 1, 1, 2'b01, 2'b01);
    load = 2'b01; div_in = {8'd0, 8'd6}; high_in = {8'd0, 8'd3};
    cyc("s3_good", 2'b01, 2'b01, 2'b00);
    load = 2'b00;
    for (int i = 0; i < 2; i++) cyc("s3_pend", 2'b00, 2'b01, 2'b00);
    cyc("s3_wrap", 2'b00, 2'b00, 2'b00);
    wave("s3_new", 6, 3, 2, 2'b01, 2'b00);

    // 4: load 6/6 exactly on the wrap cycle, pend never set
    for (int i = 0; i < 3; i++) cyc("s4_hi", 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) cyc("s4_lo", 2'b00, 2'b00, 2'b00);
    load = 2'b01; div_in = {8'd0, 8'd6}; high_in = {8'd0, 8'd6};
    cyc("s4_wrapload", 2'b00, 2'b00, 2'b00);
    load = 2'b00;
    wave("s4_const", 6, 6, 2, 2'b01, 2'b00);

    // 5: back to 10/5, disable mid-high with a pending value, load while idle
    load = 2'b01; div_in = {8'd0, 8'd10}; high_in = {8'd0, 8'd5};
    cyc("s5_load", 2'b01, 2'b01, 2'b00);
    load = 2'b00;
    for (int i = 0; i < 4; i++) cyc("s5_pend", 2'b01, 2'b01, 2'b00);
    cyc("s5_wrap", 2'b01, 2'b00, 2'b00);
    cyc("s5_c0", 2'b01, 2'b00, 2'b00);
    load = 2'b01; div_in = {8'd0, 8'd12}; high_in = {8'd0, 8'd2};
    cyc("s5_c1load", 2'b01, 2'b01, 2'b00);
    load = 2'b00;
    en   = 2'b00;
    cyc("s5_off_apply", 2'b00, 2'b00, 2'b00);
    cyc("s5_off", 2'b00, 2'b00, 2'b00);
    load = 2'b01; div_in = {8'd0, 8'd8}; high_in = {8'd0, 8'd4};
    cyc("s5_offload", 2'b00, 2'b00, 2'b00);
    load = 2'b00;
    for (int i = 0; i < 4; i++) cyc("s5_off", 2'b00, 2'b00, 2'b00);
    en = 2'b01;
    wave("s5_restart", 8, 4, 2, 2'b01, 2'b00);

    // 6: pending load on ch0 plus bad load on ch1, then reset at cnt=7
    load = 2'b11; div_in = {8'd0, 8'd20}; high_in = {8'd1, 8'd10};
    cyc("s6_load", 2'b01, 2'b01, 2'b10);
    load = 2'b00;
    for (int i = 0; i < 3; i++) cyc("s6_hi", 2'b01, 2'b01, 2'b10);
    for (int i = 0; i < 3; i++) cyc("s6_lo", 2'b00, 2'b01, 2'b10);
    reset = 1'b1;
    cyc("s6_reset", 2'b00, 2'b00, 2'b00);
    cyc("s6_reset2", 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    en    = 2'b11;
    wave("s6_default", 10, 5, 2, 2'b11, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
